rotary_encoder: RTL and testbench
=================================

Name: rotary_encoder

Overview:
- Decodes a mechanical rotary encoder: two quadrature phase inputs (rotl, rotr) plus a push-button.
- Produces sticky event flags (left detent, right detent, button press) that a host polls and clears with a read strobe.
- Sits between the board-level encoder pins and a control FSM or CPU register interface; all inputs are asynchronous to clk.

Parameters:
- SYNC_STAGES, 2, number of flip-flop synchronizer stages on rotl, rotr and push (minimum 2).
- DEBOUNCE_CYCLES, 0, consecutive stable synchronized cycles required before a push level change is accepted; 0 = no debounce.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-low reset.
- rotl  in  1  encoder phase L, asynchronous.
- rotr  in  1  encoder phase R, asynchronous.
- push  in  1  push-button, active-high, asynchronous.
- read  in  1  level-sensitive acknowledge; clears all flags on each clk edge where it is 1.
- rotl_out  out  1  sticky: a full left detent has completed since the last read.
- rotr_out  out  1  sticky: a full right detent has completed since the last read.
- push_out  out  1  sticky: a button press (rising edge) has occurred since the last read.

Behaviour:
- Reset: clr=0 asynchronously clears all outputs, synchronizers, debounce counter and push history, and forces the FSM to IDLE. The FSM leaves reset assuming phases {rotl,rotr}=00.
- Synchronize rotl, rotr and push through SYNC_STAGES flops. All decoding uses the synchronized values sL, sR and sP.
- Quadrature FSM, phase written as {sL,sR}:
  - States: IDLE(00), R1(01), R2(11), R3(10), L1(10), L2(11), L3(01), ERR.
  - Right sequence: IDLE -01-> R1 -11-> R2 -10-> R3 -00-> IDLE, pulsing right_evt.
  - Left sequence: IDLE -10-> L1 -11-> L2 -01-> L3 -00-> IDLE, pulsing left_evt.
  - A single-bit step backwards (contact bounce) returns to the previous state of the same sequence. From R1 or L1, stepping back to 00 returns to IDLE with no event.
  - An unchanged phase holds the current state.
  - A two-bit change (illegal) goes to ERR. ERR returns to IDLE only when the phase is 00, with no event.
- Flag update, every clk edge:
  - new flag = (old flag AND NOT read) OR event this cycle.
  - An event that coincides with read is never lost: the flag stays or becomes 1.
  - rotl_out and rotr_out may both be 1 if both directions occurred between reads.
  - Extra detents before a read are not counted; the flag simply stays 1.
- Push path:
  - sP is accepted as the debounced level pD after DEBOUNCE_CYCLES stable cycles; with DEBOUNCE_CYCLES=0, pD = sP.
  - push_evt = pD AND NOT pD_prev (rising edge only). Holding the button produces one event; release produces none.
- Latency, with SYNC_STAGES=2 and DEBOUNCE_CYCLES=0: a flag is 1 at the 3rd rising clk edge after the final raw input transition settles (two sync stages plus one registered flag).
- Outputs are registered. There are no combinational paths from inputs to outputs.
- read held high continuously keeps flags clear, except for the cycle in which an event occurs.

Decomposition:
- Shared package: FSM state enum (IDLE, R1, R2, R3, L1, L2, L3, ERR) and phase constants PH_00, PH_01, PH_11, PH_10.
- One natural sub-module, sync_debounce: the synchronizer chain plus optional stable-count debouncer. Instantiate it three times, with debounce disabled for the rotary phases.
- The quadrature FSM and flag registers live in the top module.

Test Plan:
- Reset: hold clr=0 with random inputs, then release -> all outputs 0, FSM IDLE; no flags after 5 idle cycles with inputs 00.
- Push: raise push, hold 4 cycles -> push_out=1 at 3rd edge and stays 1. Pulse read for 1 cycle -> push_out=0 next edge; still held push gives no new flag. Release and press again -> push_out=1.
- Right detent: drive {rotl,rotr} 00,01,11,10,00, one step per cycle -> rotr_out=1 three edges after the final 00, rotl_out=0. read=1 for one cycle -> rotr_out=0.
- Left detent: drive 00,10,11,01,00 -> rotl_out=1, rotr_out=0. Then a right detent without read -> both flags 1.
- Bounce/illegal: drive 00,01,00,01,11,01,11,10,00 -> exactly rotr_out=1. Drive 00,11,00 -> ERR then IDLE, no flag.
- Collision: assert read on the same edge that an event registers -> flag reads 1 afterwards. A second read clears it.

Source files
------------

// File: rtl/rotary_encoder_pkg.sv
// Shared types for the rotary encoder decoder: quadrature FSM states and
// phase encodings, with phase written as {sL, sR}.
package rotary_encoder_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        R1   = 3'd1,
        R2   = 3'd2,
        R3   = 3'd3,
        L1   = 3'd4,
        L2   = 3'd5,
        L3   = 3'd6,
        ERR  = 3'd7
    } state_t;

    localparam logic [1:0] PH_00 = 2'b00;
    localparam logic [1:0] PH_01 = 2'b01;
    localparam logic [1:0] PH_11 = 2'b11;
    localparam logic [1:0] PH_10 = 2'b10;

endpackage

// File: rtl/rotary_encoder_sync_debounce.sv
// Multi-flop synchronizer for one asynchronous pin, followed by an optional
// stable-count debouncer (DEBOUNCE_CYCLES = 0 bypasses it).
module rotary_encoder_sync_debounce #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic clr,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync;

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], d};
        end
    end

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_no_debounce
            assign q = sync[SYNC_STAGES-1];
        end else begin : g_debounce
            localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
            logic [CW-1:0] cnt;
            logic          level;

            // Any cycle that agrees with the accepted level restarts the count.
            always_ff @(posedge clk or negedge clr) begin
                if (!clr) begin
                    cnt   <= '0;
                    level <= 1'b0;
                end else if (sync[SYNC_STAGES-1] == level) begin
                    cnt <= '0;
                end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                    level <= sync[SYNC_STAGES-1];
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + 1'b1;
                end
            end

            assign q = level;
        end
    endgenerate

endmodule

// File: rtl/rotary_encoder.sv
// Rotary encoder decoder: synchronizes the phases and button, tracks detents
// with a quadrature FSM, and holds sticky event flags until the host reads.
module rotary_encoder
    import rotary_encoder_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 0
) (
    input  logic clk,
    input  logic clr,
    input  logic rotl,
    input  logic rotr,
    input  logic push,
    input  logic read,
    output logic rotl_out,
    output logic rotr_out,
    output logic push_out
);

    logic       s_l;
    logic       s_r;
    logic       p_d;
    logic       p_d_prev;
    logic [1:0] ph;
    state_t     state;

    rotary_encoder_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_sync_l (
        .clk(clk), .clr(clr), .d(rotl), .q(s_l)
    );

    rotary_encoder_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(0)) u_sync_r (
        .clk(clk), .clr(clr), .d(rotr), .q(s_r)
    );

    rotary_encoder_sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_sync_p (
        .clk(clk), .clr(clr), .d(push), .q(p_d)
    );

    assign ph = {s_l, s_r};

    // Flags default to "hold unless read"; a detent completing this cycle
    // overrides that, so an event coinciding with read is never dropped.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state    <= IDLE;
            rotl_out <= 1'b0;
            rotr_out <= 1'b0;
            push_out <= 1'b0;
            p_d_prev <= 1'b0;
        end else begin
            p_d_prev <= p_d;
            rotl_out <= rotl_out & ~read;
            rotr_out <= rotr_out & ~read;
            push_out <= (push_out & ~read) | (p_d & ~p_d_prev);
            case (state)
                IDLE: case (ph)
                    PH_01:   state <= R1;
                    PH_10:   state <= L1;
                    PH_11:   state <= ERR;
                    default: ;
                endcase
                R1: case (ph)
                    PH_11:   state <= R2;
                    PH_00:   state <= IDLE;
                    PH_10:   state <= ERR;
                    default: ;
                endcase
                R2: case (ph)
                    PH_10:   state <= R3;
                    PH_01:   state <= R1;
                    PH_00:   state <= ERR;
                    default: ;
                endcase
                R3: case (ph)
                    PH_00: begin
                        state    <= IDLE;
                        rotr_out <= 1'b1;
                    end
                    PH_11:   state <= R2;
                    PH_01:   state <= ERR;
                    default: ;
                endcase
                L1: case (ph)
                    PH_11:   state <= L2;
                    PH_00:   state <= IDLE;
                    PH_01:   state <= ERR;
                    default: ;
                endcase
                L2: case (ph)
                    PH_01:   state <= L3;
                    PH_10:   state <= L1;
                    PH_00:   state <= ERR;
                    default: ;
                endcase
                L3: case (ph)
                    PH_00: begin
                        state    <= IDLE;
                        rotl_out <= 1'b1;
                    end
                    PH_11:   state <= L2;
                    PH_10:   state <= ERR;
                    default: ;
                endcase
                ERR: begin
                    if (ph == PH_00) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rotary_encoder.sv
// Directed bench for rotary_encoder: the driver queues expected flag values
// {rotl_out, rotr_out, push_out} with a target cycle; the monitor compares them.
module tb_rotary_encoder;
    import rotary_encoder_pkg::*;

    logic clk = 1'b0;
    logic clr = 1'b0;
    logic rotl = 1'b0;
    logic rotr = 1'b0;
    logic push = 1'b0;
    logic read = 1'b0;
    logic rotl_out;
    logic rotr_out;
    logic push_out;

    int cyc      = 0;
    int n_checks = 0;
    int n_errors = 0;

    logic [2:0] exp_q[$];
    int         tgt_q[$];
    string      name_q[$];

    logic [2:0] mon_act;
    logic [2:0] mon_exp;
    int         mon_tgt;
    string      mon_name;

    logic [1:0] bounce_r[8] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] bounce_l[8] = '{2'b10, 2'b11, 2'b10, 2'b11, 2'b01, 2'b11, 2'b01, 2'b00};

    rotary_encoder #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(0)) dut (
        .clk(clk), .clr(clr), .rotl(rotl), .rotr(rotr), .push(push), .read(read),
        .rotl_out(rotl_out), .rotr_out(rotr_out), .push_out(push_out)
    );

    // ---------------- clock / cycle counter ----------------
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish, errors=%0d checks=%0d", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [1:0] ph, input logic p, input logic rd);
        @(negedge clk);
        {rotl, rotr} = ph;
        push = p;
        read = rd;
    endtask

    task automatic idle(input int n, input logic p);
        for (int i = 0; i < n; i++) drive(2'b00, p, 1'b0);
    endtask

    task automatic walk(input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                        input logic [1:0] d, input logic rd);
        drive(a, 1'b0, rd);
        drive(b, 1'b0, rd);
        drive(c, 1'b0, rd);
        drive(d, 1'b0, rd);
    endtask

    task automatic expect_flags(input int dly, input logic [2:0] e, input string nm);
        tgt_q.push_back(cyc + dly);
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        while (tgt_q.size() > 0 && tgt_q[0] <= cyc) begin
            mon_tgt  = tgt_q.pop_front();
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = {rotl_out, rotr_out, push_out};
            n_checks++;
            if (mon_act !== mon_exp) begin
                n_errors++;
                $display("FAIL %s cycle %0d (target %0d): flags {l,r,p}=%b expected %b",
                         mon_name, cyc, mon_tgt, mon_act, mon_exp);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        // reset with random inputs
        for (int i = 0; i < 4; i++) begin
            drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            expect_flags(1, 3'b000, "reset_hold");
        end
        drive(2'b00, 1'b0, 1'b0);
        clr = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(2'b00, 1'b0, 1'b0);
            expect_flags(1, 3'b000, "reset_idle");
        end
        @(negedge clk);
        n_checks++;
        if (dut.state !== IDLE) begin
            n_errors++;
            $display("FAIL reset_state: state=%0d expected %0d", dut.state, IDLE);
        end

        // push press, hold, read, release, press again
        drive(2'b00, 1'b1, 1'b0);
        expect_flags(2, 3'b000, "push_latency");
        expect_flags(3, 3'b001, "push_rise");
        idle(4, 1'b1);
        expect_flags(1, 3'b001, "push_hold");
        drive(2'b00, 1'b1, 1'b1);
        expect_flags(1, 3'b000, "push_read_clr");
        idle(4, 1'b1);
        expect_flags(1, 3'b000, "push_still_held");
        idle(4, 1'b0);
        expect_flags(1, 3'b000, "push_release");
        drive(2'b00, 1'b1, 1'b0);
        expect_flags(3, 3'b001, "push_repress");
        idle(3, 1'b1);
        drive(2'b00, 1'b1, 1'b1);
        expect_flags(1, 3'b000, "push_clr2");
        idle(4, 1'b0);

        // right detent
        walk(2'b01, 2'b11, 2'b10, 2'b00, 1'b0);
        expect_flags(2, 3'b000, "right_latency");
        expect_flags(3, 3'b010, "right_detent");
        idle(3, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "right_clear");
        idle(1, 1'b0);

        // left detent, then right without read
        walk(2'b10, 2'b11, 2'b01, 2'b00, 1'b0);
        expect_flags(3, 3'b100, "left_detent");
        idle(3, 1'b0);
        walk(2'b01, 2'b11, 2'b10, 2'b00, 1'b0);
        expect_flags(3, 3'b110, "both_flags");
        idle(3, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "both_clear");
        idle(1, 1'b0);

        // contact bounce within each sequence
        for (int i = 0; i < 8; i++) drive(bounce_r[i], 1'b0, 1'b0);
        expect_flags(3, 3'b010, "bounce_right");
        idle(3, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "bounce_right_clr");
        for (int i = 0; i < 8; i++) drive(bounce_l[i], 1'b0, 1'b0);
        expect_flags(3, 3'b100, "bounce_left");
        idle(3, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "bounce_left_clr");

        // illegal two-bit jump, then recovery
        drive(2'b11, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b0);
        idle(4, 1'b0);
        expect_flags(1, 3'b000, "illegal_noflag");
        walk(2'b01, 2'b11, 2'b10, 2'b00, 1'b0);
        expect_flags(3, 3'b010, "after_err");
        idle(3, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "after_err_clr");

        // read coinciding with the event edge
        walk(2'b01, 2'b11, 2'b10, 2'b00, 1'b0);
        drive(2'b00, 1'b0, 1'b0);
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b010, "collision_keep");
        drive(2'b00, 1'b0, 1'b0);
        expect_flags(1, 3'b010, "collision_hold");
        drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "collision_second_read");

        // read held high throughout a detent
        walk(2'b01, 2'b11, 2'b10, 2'b00, 1'b1);
        expect_flags(3, 3'b010, "read_held_event");
        for (int i = 0; i < 3; i++) drive(2'b00, 1'b0, 1'b1);
        expect_flags(1, 3'b000, "read_held_clear");

        idle(5, 1'b0);
        n_checks++;
        if (tgt_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: %0d pending expectations, expected 0", tgt_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
